button_conditioner: RTL and testbench

- Front-end conditioner for the manual-set push-buttons (up_s/down_s … up_y/down_y) of century_clock.
- Sits between the raw board pins and the up_*/down_* inputs of the time counters.
- Per button: 2-flop synchronizer, debounce, one-cycle press pulse, optional auto-repeat while held. The counters therefore see exactly one clk-wide pulse per intended step.

---
 rtl/button_conditioner.sv | 136 +++++++++++++
 tb/tb_button_conditioner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: per channel a 2-flop synchronizer, a debounce filter,
// a one-cycle press pulse, and an optional auto-repeat pulse train while held.
module button_conditioner #(
  parameter int unsigned NUM_BTN          = 12,
  parameter int unsigned DEBOUNCE_CYC     = 1000000,
  parameter int unsigned REPEAT_DELAY_CYC = 50000000,
  parameter int unsigned REPEAT_RATE_CYC  = 10000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_repeat,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned RMAX   = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                   REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int unsigned RCNT_W = $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  logic [NUM_BTN-1:0] s1_q;
  logic [NUM_BTN-1:0] s2_q;

  // Two-flop synchronizer for the asynchronous button pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lvl_q, lvl_d;
    logic              rise_c, fall_c;
    state_e            state_q, state_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              pulse_q, pulse_d;

    // Debounce: the mismatch must be seen on DEBOUNCE_CYC+1 consecutive edges,
    // which puts the accepted level 2+DEBOUNCE_CYC edges after the raw step.
    always_comb begin
      cnt_d  = '0;
      lvl_d  = lvl_q;
      rise_c = 1'b0;
      fall_c = 1'b0;
      if (s2_q[i] != lvl_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYC)) begin
          lvl_d  = s2_q[i];
          rise_c = s2_q[i];
          fall_c = ~s2_q[i];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Channel FSM: press pulse, repeat delay, then fixed-rate repeat
    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      pulse_d = 1'b0;
      if (fall_c) begin
        state_d = ST_IDLE;
        rcnt_d  = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise_c) begin
              pulse_d = 1'b1;
              rcnt_d  = '0;
              state_d = ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (!en_repeat) begin
              rcnt_d = '0;
            end else if (rcnt_q == RCNT_W'(REPEAT_DELAY_CYC - 1)) begin
              pulse_d = 1'b1;
              rcnt_d  = '0;
              state_d = ST_REPEAT;
            end else begin
              rcnt_d = rcnt_q + RCNT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (!en_repeat) begin
              rcnt_d  = '0;
              state_d = ST_HOLD;
            end else if (rcnt_q == RCNT_W'(REPEAT_RATE_CYC - 1)) begin
              pulse_d = 1'b1;
              rcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q + RCNT_W'(1);
            end
          end
          default: begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
          end
        endcase
      end
    end

    // Per-channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        state_q <= ST_IDLE;
        rcnt_q  <= '0;
        pulse_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
        pulse_q <= pulse_d;
      end
    end

    assign btn_level[i] = lvl_q;
    assign btn_pulse[i] = pulse_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity,
// each cycle compared against a timestamp-based behavioural model.
module tb_button_conditioner;
  localparam int NB = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_repeat;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYC(DB), .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_repeat(en_repeat),
    .btn_raw(btn_raw), .btn_level(btn_level), .btn_pulse(btn_pulse)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: raw samples pass through two stages; a level change is accepted
  // DB edges after the disagreement first shows at the synchronizer output.
  // Repeat pulses are scheduled as absolute cycle numbers.
  logic [NB-1:0] m_s1, m_s2, m_lvl, m_pulse;
  int m_since [NB];
  bit m_held  [NB];
  int m_next  [NB];
  int cyc = 0;

  // Per-scenario observations of the DUT, indexed by edge number
  int t;
  int pq [NB][$];
  int fall_t [NB];
  bit lvl_seen [NB];
  int xq [$];

  task automatic chk(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s t=%0d: observed %b expected %b", tag, t, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0;
    for (int i = 0; i < NB; i++) begin
      m_since[i] = -1;
      m_held[i]  = 1'b0;
      m_next[i]  = 0;
    end
  endtask

  task automatic model_edge();
    bit acc;
    m_pulse = '0;
    for (int i = 0; i < NB; i++) begin
      acc = 1'b0;
      if (m_s2[i] != m_lvl[i]) begin
        if (m_since[i] < 0) m_since[i] = cyc;
        if (cyc - m_since[i] == DB) acc = 1'b1;
      end else begin
        m_since[i] = -1;
      end
      if (acc) begin
        m_lvl[i]   = m_s2[i];
        m_since[i] = -1;
        if (m_lvl[i]) begin
          m_held[i]  = 1'b1;
          m_pulse[i] = 1'b1;
          m_next[i]  = cyc + RD;
        end else begin
          m_held[i] = 1'b0;
        end
      end else if (m_held[i]) begin
        if (!en_repeat) m_next[i] = cyc + RD;
        else if (cyc == m_next[i]) begin
          m_pulse[i] = 1'b1;
          m_next[i]  = cyc + RR;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_raw;
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("level", btn_level, m_lvl);
    chk("pulse", btn_pulse, m_pulse);
    for (int i = 0; i < NB; i++) begin
      if (btn_pulse[i]) pq[i].push_back(t);
      if (btn_level[i]) lvl_seen[i] = 1'b1;
      else if (lvl_seen[i] && fall_t[i] < 0) fall_t[i] = t;
    end
    t++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic begin_scn();
    t = 0;
    for (int i = 0; i < NB; i++) begin
      pq[i].delete();
      fall_t[i]   = -1;
      lvl_seen[i] = 1'b0;
    end
  endtask

  task automatic check_pulses(input string tag, input int ch);
    chk_int({tag, "_count"}, pq[ch].size(), xq.size());
    if (pq[ch].size() == xq.size())
      for (int k = 0; k < xq.size(); k++) chk_int({tag, "_edge"}, pq[ch][k], xq[k]);
  endtask

  initial begin
    int bounce [12];
    bounce = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0};

    // Reset state
    rst_n = 1'b0; btn_raw = '0; en_repeat = 1'b0; t = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_level", btn_level, 2'b00);
    chk("reset_pulse", btn_pulse, 2'b00);
    rst_n = 1'b1;
    run(3);

    // Clean press, no repeat: single pulse at edge 6, release latency 6
    begin_scn();
    btn_raw = 2'b01;
    run(8);
    btn_raw = 2'b00;
    run(14);
    xq.delete(); xq.push_back(6);
    check_pulses("clean_ch0", 0);
    xq.delete();
    check_pulses("clean_ch1", 1);
    chk_int("clean_fall", fall_t[0], 14);

    // Bounce rejection: 1-, 2-, 3-cycle glitches
    begin_scn();
    for (int k = 0; k < 12; k++) begin
      btn_raw = bounce[k] ? 2'b01 : 2'b00;
      tick();
    end
    btn_raw = 2'b00;
    run(10);
    xq.delete();
    check_pulses("bounce_pulse", 0);
    chk_int("bounce_level", int'(lvl_seen[0]), 0);

    // Auto-repeat on channel 1
    begin_scn();
    en_repeat = 1'b1;
    btn_raw = 2'b10;
    run(28);
    btn_raw = 2'b00;
    run(16);
    xq = {6, 16, 19, 22, 25, 28, 31};
    check_pulses("repeat_ch1", 1);
    chk_int("repeat_fall_by_38", int'(fall_t[1] >= 0 && fall_t[1] <= 38), 1);

    // en_repeat toggle while held
    begin_scn();
    en_repeat = 1'b1;
    btn_raw = 2'b01;
    run(21);
    en_repeat = 1'b0;
    run(5);
    en_repeat = 1'b1;
    run(20);
    xq = {6, 16, 19, 35, 38, 41, 44};
    check_pulses("toggle_ch0", 0);
    btn_raw = 2'b00;
    run(12);

    // Simultaneous press on both channels
    begin_scn();
    en_repeat = 1'b0;
    btn_raw = 2'b11;
    run(10);
    xq.delete(); xq.push_back(6);
    check_pulses("simul_ch0", 0);
    check_pulses("simul_ch1", 1);
    btn_raw = 2'b00;
    run(10);

    // Reset while repeating with the button held
    begin_scn();
    en_repeat = 1'b1;
    btn_raw = 2'b10;
    run(23);
    chk("pre_reset_level", btn_level, 2'b10);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_level", btn_level, 2'b00);
    chk("async_reset_pulse", btn_pulse, 2'b00);
    @(posedge clk);
    #1;
    chk("held_reset_level", btn_level, 2'b00);
    rst_n = 1'b1;
    begin_scn();
    run(23);
    xq = {6, 16, 19, 22};
    check_pulses("post_reset_ch1", 1);
    btn_raw = 2'b00;
    run(12);

    // Random button activity with random repeat enable
    begin_scn();
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 11) == 0) btn_raw[i] = ~btn_raw[i];
      if ($urandom_range(0, 39) == 0) en_repeat = ~en_repeat;
      tick();
    end
    btn_raw = 2'b00;
    run(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
